// File: rtl/alu_exec_pkg.sv
// Shared constants and types for the execute-stage ALU block:
// ALUOp and funct encodings, the ALU control code enum, and the default datapath width.
package alu_exec_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_MUL = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: main-control ALUOp plus instruction funct field -> ALU operation code.
// MUL is decoded only when ALU_EXEC_MUL_EN is defined; otherwise its funct falls back to ADD.
module alu_ctrl_dec
  import alu_exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_ctrl_t  alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_OR:  alu_ctrl = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
`ifdef ALU_EXEC_MUL_EN
          FUNCT_MUL: alu_ctrl = ALU_MUL;
`endif
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic: ALU control decode, ALU, independent address adder, EX/MEM result register.
// Define ALU_EXEC_MUL_EN to build the signed multiplier (ALU code 011); without it code 011 yields 0.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [WIDTH-1:0] add_a_i,
  input  logic [WIDTH-1:0] add_b_i,
  output logic [2:0]       ALUCtrl_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] result_q_o,
  output logic             zero_q_o
);

  alu_ctrl_t alu_ctrl;

  alu_ctrl_dec u_dec (
    .alu_op   (ALUOp_i),
    .funct    (funct_i),
    .alu_ctrl (alu_ctrl)
  );

`ifdef ALU_EXEC_MUL_EN
  logic signed [WIDTH-1:0] prod;
  assign prod = $signed(data1_i) * $signed(data2_i);
`endif

  always_comb begin
    data_o = '0;
    case (alu_ctrl)
      ALU_AND: data_o = data1_i & data2_i;
      ALU_OR:  data_o = data1_i | data2_i;
      ALU_ADD: data_o = data1_i + data2_i;
      ALU_SUB: data_o = data1_i - data2_i;
      ALU_SLT: data_o = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
`ifdef ALU_EXEC_MUL_EN
      ALU_MUL: data_o = prod;
`endif
      default: data_o = '0;
    endcase
  end

  assign ALUCtrl_o = alu_ctrl;
  assign zero_o    = (data_o == '0);
  assign sum_o     = add_a_i + add_b_i;

  // Reset value mirrors a zero result so branch logic sees a consistent pair.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q_o <= '0;
      zero_q_o   <= 1'b1;
    end else if (!stall_i) begin
      result_q_o <= data_o;
      zero_q_o   <= zero_o;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expected values are hand-computed constants.
// MUL expectation follows ALU_EXEC_MUL_EN as seen by the bench.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [31:0] d1 = '0, d2 = '0, add_a = '0, add_b = '0;
  logic [2:0]  alu_ctrl;
  logic [31:0] data, sum, result_q;
  logic        zero, zero_q;

  int tests = 0;
  int fails = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .stall_i    (stall),
    .ALUOp_i    (alu_op),
    .funct_i    (funct),
    .data1_i    (d1),
    .data2_i    (d2),
    .add_a_i    (add_a),
    .add_b_i    (add_b),
    .ALUCtrl_o  (alu_ctrl),
    .data_o     (data),
    .zero_o     (zero),
    .sum_o      (sum),
    .result_q_o (result_q),
    .zero_q_o   (zero_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one ALU vector on the falling edge, check combinational outputs,
  // then check the registered copy after the next rising edge.
  task automatic alu_vec(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] exp_ctrl, input logic [31:0] exp_data,
                         input logic exp_zero);
    @(negedge clk);
    alu_op = op; funct = fn; d1 = a; d2 = b;
    #1;
    check({tag, ".ctrl"}, {29'd0, alu_ctrl}, {29'd0, exp_ctrl});
    check({tag, ".data"}, data, exp_data);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
    @(posedge clk); #1;
    check({tag, ".result_q"}, result_q, exp_data);
    check({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, exp_zero});
  endtask

  initial begin
    // Load a non-zero result, then reset asynchronously mid-cycle.
    alu_vec("pre_rst", 2'b00, 6'd0, 32'h0000_1230, 32'h4, 3'b010, 32'h0000_1234, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.result_q", result_q, 32'h0);
    check("rst.zero_q", {31'd0, zero_q}, 32'h1);
    // Release reset while stalled: outputs must stay in reset state.
    alu_op = 2'b00; d1 = 32'h77; d2 = 32'h1;
    stall = 1'b1;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall.result_q", result_q, 32'h0);
    check("rst_stall.zero_q", {31'd0, zero_q}, 32'h1);
    @(negedge clk); stall = 1'b0;

    alu_vec("sub_r",   2'b10, 6'b100010, 32'd5, 32'd7, 3'b110, 32'hFFFF_FFFE, 1'b0);
    alu_vec("beq",     2'b01, 6'b000000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b110, 32'h0, 1'b1);
    alu_vec("add_wrap",2'b00, 6'b000000, 32'hFFFF_FFFF, 32'h1, 3'b010, 32'h0, 1'b1);
    alu_vec("and",     2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_0FF0, 3'b000, 32'h0000_00F0, 1'b0);
    alu_vec("or",      2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_0FF0, 3'b001, 32'h0000_FFF0, 1'b0);
    alu_vec("slt_t",   2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1, 3'b111, 32'h1, 1'b0);
    alu_vec("slt_f",   2'b10, 6'b101010, 32'h1, 32'hFFFF_FFFF, 3'b111, 32'h0, 1'b1);
    alu_vec("add_r",   2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h1, 3'b010, 32'h8000_0000, 1'b0);
    alu_vec("ori",     2'b11, 6'b101010, 32'h0000_00F0, 32'h0000_000F, 3'b001, 32'h0000_00FF, 1'b0);
    alu_vec("bad_fn",  2'b10, 6'b111111, 32'h10, 32'h20, 3'b010, 32'h30, 1'b0);
`ifdef ALU_EXEC_MUL_EN
    alu_vec("mul",     2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7, 3'b011, 32'hFFFF_FFEB, 1'b0);
`else
    alu_vec("mul",     2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7, 3'b010, 32'h0000_0004, 1'b0);
`endif

    // Adder is independent of the ALU path.
    @(negedge clk);
    add_a = 32'h0040_0000; add_b = 32'h4;
    #1 check("sum.pc4", sum, 32'h0040_0004);
    add_a = 32'hFFFF_FFFF; add_b = 32'h2;
    #1 check("sum.wrap", sum, 32'h0000_0001);

    // Stall: capture 0x55, then change inputs for 3 stalled edges.
    alu_vec("pre_stall", 2'b00, 6'd0, 32'h50, 32'h5, 3'b010, 32'h55, 1'b0);
    @(negedge clk); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_op = 2'b01; d1 = 32'(i); d2 = 32'(i);
      @(posedge clk); #1;
      check("stall.result_q", result_q, 32'h55);
      check("stall.zero_q", {31'd0, zero_q}, 32'h0);
    end
    @(negedge clk);
    stall = 1'b0; alu_op = 2'b00; d1 = 32'h100; d2 = 32'h23;
    @(posedge clk); #1;
    check("unstall.result_q", result_q, 32'h123);
    check("unstall.zero_q", {31'd0, zero_q}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
